// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-at-a-time arbiter/sequencer sharing a single-port memory between
// instruction fetch and load/store. Define ARB_FAIRNESS_EN to bound fetch starvation.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e              state_q, state_d;
    logic [LAT_W-1:0]    cnt_q, cnt_d;
    logic                owner_dm_q, owner_dm_d;
    logic                store_q, store_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                arb_slot, force_if, pick_dm, pick_if;

`ifdef ARB_FAIRNESS_EN
    localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    logic [STARVE_W-1:0] starve_q, starve_d;
`endif

    // Grants are combinational and only offered while idle or in the response cycle.
    always_comb begin
        arb_slot = rst && ((state_q == S_IDLE) || (state_q == S_RESP));
`ifdef ARB_FAIRNESS_EN
        force_if = if_req && dm_req && (starve_q == STARVE_W'(STARVE_MAX));
`else
        force_if = 1'b0;
`endif
        pick_dm  = arb_slot && dm_req && !force_if;
        pick_if  = arb_slot && if_req && !pick_dm;
    end

`ifdef ARB_FAIRNESS_EN
    // Saturating count of contested data wins; any fetch grant clears it.
    always_comb begin
        starve_d = starve_q;
        if (pick_if) begin
            starve_d = '0;
        end else if (pick_dm && if_req && (starve_q != STARVE_W'(STARVE_MAX))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end
`endif

    // Sequencer next state and registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_dm_d  = owner_dm_q;
        store_d     = store_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE, S_RESP: begin
                if (pick_dm || pick_if) begin
                    state_d    = S_ISSUE;
                    owner_dm_d = pick_dm;
                    store_d    = pick_dm && dm_we;
                    mem_en_d   = 1'b1;
                    mem_we_d   = pick_dm && dm_we;
                    mem_addr_d = pick_dm ? dm_addr : if_addr;
                    if (pick_dm) begin
                        mem_wdata_d = dm_wdata;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = LAT_W'(MEM_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (owner_dm_q) begin
                        dm_rvalid_d = 1'b1;
                        if (!store_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_dm_q  <= 1'b0;
            store_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef ARB_FAIRNESS_EN
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_dm_q  <= owner_dm_d;
            store_q     <= store_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef ARB_FAIRNESS_EN
            starve_q    <= starve_d;
`endif
        end
    end

    assign if_gnt    = pick_if;
    assign dm_gnt    = pick_dm;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, contention and reset-mid-op sequences,
// then random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned LAT  = 2;
    localparam int unsigned SMAX = 4;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory device: read data is valid exactly LAT cycles after the mem_en cycle, junk otherwise.
    logic [DW-1:0] dev_mem [logic [AW-1:0]];
    logic [DW-1:0] pipe_d [LAT];
    logic          pipe_v [LAT];

    initial for (int i = 0; i < LAT; i++) pipe_v[i] = 1'b0;

    always @(posedge clk) begin
        pipe_v[0] <= mem_en && !mem_we;
        pipe_d[0] <= dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_word(mem_addr);
        for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
        if (mem_en && mem_we) dev_mem[mem_addr] = mem_wdata;
    end
    assign mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hBAD0_BAD0;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          ifr;
        logic [AW-1:0] ifa;
        logic          dmr;
        logic          dmwe;
        logic [AW-1:0] dma;
        logic [DW-1:0] dmwd;
        logic          ifg;
        logic          dmg;
        logic          men;
        logic          mwe;
        logic [AW-1:0] madr;
        logic          ifrv;
        logic [DW-1:0] ifrd;
        logic          dmrv;
        logic [DW-1:0] dmrd;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input int r, input int ifr, input logic [AW-1:0] ifa,
                                input int dmr, input int dmwe, input logic [AW-1:0] dma,
                                input logic [DW-1:0] dmwd, input int ifg, input int dmg,
                                input int men, input int mwe, input logic [AW-1:0] madr,
                                input int ifrv, input logic [DW-1:0] ifrd,
                                input int dmrv, input logic [DW-1:0] dmrd);
        vec_t v;
        v.rst = (r != 0);    v.ifr = (ifr != 0);  v.ifa = ifa;
        v.dmr = (dmr != 0);  v.dmwe = (dmwe != 0); v.dma = dma; v.dmwd = dmwd;
        v.ifg = (ifg != 0);  v.dmg = (dmg != 0);  v.men = (men != 0); v.mwe = (mwe != 0);
        v.madr = madr;       v.ifrv = (ifrv != 0); v.ifrd = ifrd;
        v.dmrv = (dmrv != 0); v.dmrd = dmrd;
        return v;
    endfunction

    // Reference model state (transaction level: one outstanding access, cycle stamps).
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            busy_until, tx_g, starve, t;
    bit            tx_v, tx_dm, tx_we, cont, got, if_seen, dm_seen;
    logic [AW-1:0] tx_addr;
    logic [DW-1:0] tx_wdata, tx_data, e_if_rd, e_dm_rd;
    logic          e_ifg, e_dmg, e_men, e_mwe, e_ifrv, e_dmrv;
    logic [DW-1:0] w_i, w_w, w_d;

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        dev_mem[32'h10] = 32'h0050_0093;
        w_i = 32'h0050_0093;
        w_w = init_word(32'h40);
        w_d = 32'hDEAD_BEEF;

        // Reset with both requests, single fetch, then load / store / load to 0x40.
        tbl.push_back(mk(0,1,'h10,1,1,'h40,w_d, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,'h10,1,1,'h40,w_d, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,1,'h10,0,0,0,0,      1,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,1,0,'h10, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,'h40,0,      0,1,0,0,0, 1,w_i,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,1,0,'h40, 0,w_i,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,0,0,0, 0,w_i,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,0,0,0, 0,w_i,0,0));
        tbl.push_back(mk(1,0,0,1,1,'h40,w_d,    0,1,0,0,0, 0,w_i,1,w_w));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,1,1,'h40, 0,w_i,0,w_w));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,0,0,0, 0,w_i,0,w_w));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,0,0,0, 0,w_i,0,w_w));
        tbl.push_back(mk(1,0,0,1,0,'h40,0,      0,1,0,0,0, 0,w_i,1,w_w));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,1,0,'h40, 0,w_i,0,w_w));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,0,0,0, 0,w_i,0,w_w));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,0,0,0, 0,w_i,0,w_w));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,0,0,0, 0,w_i,1,w_d));
        tbl.push_back(mk(1,0,0,0,0,0,0,         0,0,0,0,0, 0,w_i,0,w_d));

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rst = tbl[i].rst; if_req = tbl[i].ifr; if_addr = tbl[i].ifa;
            dm_req = tbl[i].dmr; dm_we = tbl[i].dmwe; dm_addr = tbl[i].dma; dm_wdata = tbl[i].dmwd;
            @(negedge clk);
            chk($sformatf("vec%0d_if_gnt", i), 64'(if_gnt), 64'(tbl[i].ifg));
            chk($sformatf("vec%0d_dm_gnt", i), 64'(dm_gnt), 64'(tbl[i].dmg));
            chk($sformatf("vec%0d_mem_en", i), 64'(mem_en), 64'(tbl[i].men));
            chk($sformatf("vec%0d_mem_we", i), 64'(mem_we), 64'(tbl[i].mwe));
            chk($sformatf("vec%0d_if_rvalid", i), 64'(if_rvalid), 64'(tbl[i].ifrv));
            chk($sformatf("vec%0d_if_rdata", i), 64'(if_rdata), 64'(tbl[i].ifrd));
            chk($sformatf("vec%0d_dm_rvalid", i), 64'(dm_rvalid), 64'(tbl[i].dmrv));
            chk($sformatf("vec%0d_dm_rdata", i), 64'(dm_rdata), 64'(tbl[i].dmrd));
            if (tbl[i].men || !tbl[i].rst)
                chk($sformatf("vec%0d_mem_addr", i), 64'(mem_addr), 64'(tbl[i].madr));
            if (tbl[i].mwe)
                chk($sformatf("vec%0d_mem_wdata", i), 64'(mem_wdata), 64'(w_d));
        end

        // Contention: both requests held continuously.
        @(posedge clk); #1 rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        @(posedge clk); #1 rst = 1'b1; if_req = 1'b1; if_addr = 32'h2000;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
        for (int k = 0; k < 10; k++) begin
            t = 0; got = 1'b0;
            while (!got && t < 3 * (LAT + 2)) begin
                @(negedge clk);
                t++;
                if (if_gnt || dm_gnt) got = 1'b1;
            end
            chk($sformatf("contend%0d_granted", k), 64'(got), 64'(1));
            chk($sformatf("contend%0d_winner", k), 64'({if_gnt, dm_gnt}),
                (FAIR && (k % (SMAX + 1) == SMAX)) ? 64'(2'b10) : 64'(2'b01));
            if (k > 0) chk($sformatf("contend%0d_spacing", k), 64'(t), 64'(LAT + 2));
        end
        @(posedge clk); #1 if_req = 1'b0; dm_req = 1'b0;
        repeat (LAT + 4) @(posedge clk);

        // Reset dropped in the first WAIT cycle.
        #1 if_req = 1'b1; if_addr = 32'h2400;
        @(negedge clk); chk("rmid_gnt", 64'(if_gnt), 64'(1));
        @(posedge clk); #1 if_req = 1'b0;
        @(negedge clk); chk("rmid_mem_en", 64'(mem_en), 64'(1));
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            chk($sformatf("rmid_quiet%0d_rvalid", k), 64'({if_rvalid, dm_rvalid}), 64'(0));
            chk($sformatf("rmid_quiet%0d_mem_en", k), 64'(mem_en), 64'(0));
            @(posedge clk); #1;
        end
        if_req = 1'b1; if_addr = 32'h2400;
        @(negedge clk); chk("rmid_regrant", 64'(if_gnt), 64'(1));
        @(posedge clk); #1 if_req = 1'b0;
        t = 0; got = 1'b0;
        while (!got && t < 4 * (LAT + 2)) begin
            @(negedge clk);
            t++;
            if (if_rvalid) got = 1'b1;
        end
        chk("rmid_resp_seen", 64'(got), 64'(1));
        chk("rmid_resp_latency", 64'(t), 64'(LAT + 2));
        chk("rmid_resp_data", 64'(if_rdata), 64'(init_word(32'h2400)));

        // Random traffic against the reference model.
        @(posedge clk); #1 rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        tx_v = 1'b0; busy_until = 1; starve = 0; e_if_rd = '0; e_dm_rd = '0;
        if_seen = 1'b0; dm_seen = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 249) != 0);
            if (if_seen) if_req = 1'b0;
            if (dm_seen) dm_req = 1'b0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req   = 1'b1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
                dm_wdata = $urandom;
            end

            cont  = if_req && dm_req;
            e_ifg = 1'b0;
            e_dmg = 1'b0;
            if (rst && n >= busy_until && (if_req || dm_req)) begin
                if (dm_req && !(FAIR && cont && starve == SMAX)) e_dmg = 1'b1;
                else e_ifg = 1'b1;
            end
            e_men  = tx_v && (n == tx_g + 1);
            e_mwe  = e_men && tx_we;
            e_ifrv = tx_v && !tx_dm && (n == tx_g + 2 + LAT);
            e_dmrv = tx_v && tx_dm && (n == tx_g + 2 + LAT);
            if (e_ifrv) e_if_rd = tx_data;
            if (e_dmrv && !tx_we) e_dm_rd = tx_data;

            @(negedge clk);
            if_seen = if_gnt;
            dm_seen = dm_gnt;
            chk($sformatf("rnd%0d_if_gnt", n), 64'(if_gnt), 64'(e_ifg));
            chk($sformatf("rnd%0d_dm_gnt", n), 64'(dm_gnt), 64'(e_dmg));
            chk($sformatf("rnd%0d_mem_en", n), 64'(mem_en), 64'(e_men));
            chk($sformatf("rnd%0d_mem_we", n), 64'(mem_we), 64'(e_mwe));
            chk($sformatf("rnd%0d_if_rvalid", n), 64'(if_rvalid), 64'(e_ifrv));
            chk($sformatf("rnd%0d_dm_rvalid", n), 64'(dm_rvalid), 64'(e_dmrv));
            chk($sformatf("rnd%0d_if_rdata", n), 64'(if_rdata), 64'(e_if_rd));
            chk($sformatf("rnd%0d_dm_rdata", n), 64'(dm_rdata), 64'(e_dm_rd));
            if (e_men) chk($sformatf("rnd%0d_mem_addr", n), 64'(mem_addr), 64'(tx_addr));
            if (e_mwe) chk($sformatf("rnd%0d_mem_wdata", n), 64'(mem_wdata), 64'(tx_wdata));

            if (!rst) begin
                tx_v = 1'b0; busy_until = n + 1; starve = 0;
                e_if_rd = '0; e_dm_rd = '0;
            end else if (e_ifg || e_dmg) begin
                tx_v     = 1'b1;
                tx_g     = n;
                tx_dm    = e_dmg;
                tx_we    = e_dmg && dm_we;
                tx_addr  = e_dmg ? dm_addr : if_addr;
                tx_wdata = dm_wdata;
                if (tx_we) ref_mem[tx_addr] = dm_wdata;
                else tx_data = ref_mem.exists(tx_addr) ? ref_mem[tx_addr] : init_word(tx_addr);
                busy_until = n + 2 + LAT;
                if (e_ifg) starve = 0;
                else if (cont && starve < SMAX) starve++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
